// File: rtl/cr16_writeback.sv
// CR16 write-back stage: merges ALU results and in-order load returns into a
// single registered register-file write, tracks outstanding load destinations
// in a small tag FIFO and keeps a per-register busy scoreboard so that an ALU
// write can never overtake a pending load to the same register.
module cr16_writeback #(
  parameter int LOAD_DEPTH = 4
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ALU_VALID,
  input  logic [3:0]  I_ALU_DEST,
  input  logic [15:0] I_ALU_DATA,
  output logic        O_ALU_READY,
  input  logic        I_LOAD_ISSUE,
  input  logic [3:0]  I_LOAD_DEST,
  output logic        O_LOAD_READY,
  input  logic        I_MEM_VALID,
  input  logic [15:0] I_MEM_DATA,
  output logic [15:0] O_REG_BUS,
  output logic [15:0] O_REG_ENABLE,
  output logic [15:0] O_BUSY,
  output logic        O_ERR
);

  localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOAD_DEPTH);

  logic [3:0]       tag_mem [LOAD_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      busy;
  logic [15:0]      busy_next;
  logic [15:0]      reg_bus;
  logic [15:0]      reg_enable;
  logic             err;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             alu_go;
  logic [3:0]       head_tag;

  // Readiness uses pre-pop state: a full FIFO refuses issue even when a
  // return frees a slot this cycle, and a register being returned stays busy.
  always_comb begin
    full         = (count == CNT_FULL);
    empty        = (count == '0);
    head_tag     = tag_mem[rd_ptr];
    O_LOAD_READY = !full && !busy[I_LOAD_DEST];
    O_ALU_READY  = !I_MEM_VALID && !busy[I_ALU_DEST];
    push         = I_LOAD_ISSUE && O_LOAD_READY;
    pop          = I_MEM_VALID && !empty;
    alu_go       = I_ALU_VALID && O_ALU_READY;
  end

  // Scoreboard next state; a pushed dest is never the popped tag because the
  // popped tag is still busy, so set/clear never collide on one bit.
  always_comb begin
    busy_next = busy;
    if (push) busy_next[I_LOAD_DEST] = 1'b1;
    if (pop)  busy_next[head_tag]    = 1'b0;
  end

  // Tag FIFO storage, pointers and occupancy count.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      for (int i = 0; i < LOAD_DEPTH; i++) tag_mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= I_LOAD_DEST;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Busy scoreboard and sticky error for a return with nothing outstanding.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_next;
      if (I_MEM_VALID && empty) err <= 1'b1;
    end
  end

  // Registered regfile write; memory returns win, bus holds when idle.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      reg_bus    <= '0;
      reg_enable <= '0;
    end else if (pop) begin
      reg_bus    <= I_MEM_DATA;
      reg_enable <= 16'h0001 << head_tag;
    end else if (alu_go) begin
      reg_bus    <= I_ALU_DATA;
      reg_enable <= 16'h0001 << I_ALU_DEST;
    end else begin
      reg_enable <= '0;
    end
  end

  assign O_REG_BUS    = reg_bus;
  assign O_REG_ENABLE = reg_enable;
  assign O_BUSY       = busy;
  assign O_ERR        = err;

endmodule

// File: tb/tb_cr16_writeback.sv
// Scoreboard bench for cr16_writeback: a queue-based reference model predicts
// readiness, the write sequence, busy bits and the error flag.
module tb_cr16_writeback;

  localparam int LOAD_DEPTH = 4;

  logic        I_CLK = 1'b0;
  logic        I_NRESET;
  logic        I_ALU_VALID;
  logic [3:0]  I_ALU_DEST;
  logic [15:0] I_ALU_DATA;
  logic        O_ALU_READY;
  logic        I_LOAD_ISSUE;
  logic [3:0]  I_LOAD_DEST;
  logic        O_LOAD_READY;
  logic        I_MEM_VALID;
  logic [15:0] I_MEM_DATA;
  logic [15:0] O_REG_BUS;
  logic [15:0] O_REG_ENABLE;
  logic [15:0] O_BUSY;
  logic        O_ERR;

  cr16_writeback #(.LOAD_DEPTH(LOAD_DEPTH)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET),
    .I_ALU_VALID(I_ALU_VALID), .I_ALU_DEST(I_ALU_DEST), .I_ALU_DATA(I_ALU_DATA),
    .O_ALU_READY(O_ALU_READY),
    .I_LOAD_ISSUE(I_LOAD_ISSUE), .I_LOAD_DEST(I_LOAD_DEST), .O_LOAD_READY(O_LOAD_READY),
    .I_MEM_VALID(I_MEM_VALID), .I_MEM_DATA(I_MEM_DATA),
    .O_REG_BUS(O_REG_BUS), .O_REG_ENABLE(O_REG_ENABLE), .O_BUSY(O_BUSY), .O_ERR(O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct packed {
    logic [15:0] en;
    logic [15:0] data;
  } wr_t;

  logic [3:0] pend[$];
  wr_t        expq[$];
  bit         err_m = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic bit in_pend(input logic [3:0] r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    foreach (pend[i]) b[pend[i]] = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, check readiness,
  // then advance the reference model by what the spec says gets accepted.
  task automatic drive(input bit av, input logic [3:0] ad, input logic [15:0] adata,
                       input bit lv, input logic [3:0] ld,
                       input bit mv, input logic [15:0] md,
                       output bit alu_acc, output bit ld_acc);
    bit exp_lr, exp_ar;
    logic [3:0] t;
    @(negedge I_CLK); #1;
    I_ALU_VALID = av; I_ALU_DEST = ad; I_ALU_DATA = adata;
    I_LOAD_ISSUE = lv; I_LOAD_DEST = ld;
    I_MEM_VALID = mv; I_MEM_DATA = md;
    #1;
    exp_lr = (pend.size() < LOAD_DEPTH) && !in_pend(ld);
    exp_ar = !mv && !in_pend(ad);
    check("load_ready", {15'b0, O_LOAD_READY}, {15'b0, exp_lr});
    check("alu_ready", {15'b0, O_ALU_READY}, {15'b0, exp_ar});
    alu_acc = av && exp_ar;
    ld_acc  = lv && exp_lr;
    if (mv) begin
      if (pend.size() > 0) begin
        t = pend.pop_front();
        expq.push_back('{en: 16'h0001 << t, data: md});
      end else begin
        err_m = 1'b1;
      end
    end else if (alu_acc) begin
      expq.push_back('{en: 16'h0001 << ad, data: adata});
    end
    if (ld_acc) pend.push_back(ld);
  endtask

  task automatic idle();
    bit a, l;
    drive(0, 4'd0, 16'h0, 0, 4'd0, 0, 16'h0, a, l);
  endtask

  // Keep presenting an ALU write until the model says it is accepted.
  task automatic alu_until(input logic [3:0] ad, input logic [15:0] adata);
    bit a, l;
    for (int n = 0; n < 12; n++) begin
      drive(1, ad, adata, 0, 4'd0, 0, 16'h0, a, l);
      if (a) return;
    end
    miscompares++;
    $display("FAIL alu_timeout actual=not_accepted required=accepted dest=%0d", ad);
  endtask

  // Monitor: after each rising edge compare any presented write with the
  // scoreboard head, and check bus hold, busy bits and the error flag.
  initial begin : monitor
    logic [15:0] last_bus;
    wr_t w;
    last_bus = 16'h0;
    forever begin
      @(posedge I_CLK); #1;
      if (!I_NRESET) begin
        last_bus = 16'h0;
        check("enable_in_reset", O_REG_ENABLE, 16'h0);
      end else if (O_REG_ENABLE != 16'h0) begin
        if (expq.size() == 0) begin
          check("unexpected_write", O_REG_ENABLE, 16'h0);
        end else begin
          w = expq.pop_front();
          check("write_enable", O_REG_ENABLE, w.en);
          check("write_data", O_REG_BUS, w.data);
        end
        last_bus = O_REG_BUS;
      end else begin
        check("bus_hold", O_REG_BUS, last_bus);
      end
      check("busy", O_BUSY, model_busy());
      check("err", {15'b0, O_ERR}, {15'b0, err_m});
    end
  end

  initial begin : stim
    bit a, l, mv;
    I_NRESET = 1'b0;
    I_ALU_VALID = 0; I_ALU_DEST = 0; I_ALU_DATA = 0;
    I_LOAD_ISSUE = 0; I_LOAD_DEST = 0; I_MEM_VALID = 0; I_MEM_DATA = 0;
    #12;
    check("rst_bus", O_REG_BUS, 16'h0);
    check("rst_enable", O_REG_ENABLE, 16'h0);
    check("rst_busy", O_BUSY, 16'h0);
    check("rst_err", {15'b0, O_ERR}, 16'h0);
    @(negedge I_CLK); I_NRESET = 1'b1;

    // ALU write r5, then an idle cycle (bus must hold A5A5).
    drive(1, 4'd5, 16'hA5A5, 0, 4'd0, 0, 16'h0, a, l);
    idle(); idle();

    // Load r3, three-cycle wait, return 1234.
    drive(0, 4'd0, 16'h0, 1, 4'd3, 0, 16'h0, a, l);
    idle(); idle();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 1, 16'h1234, a, l);
    idle();

    // Fill the FIFO with r1,r2,r4,r8; r9 must be refused; return 1..4.
    drive(0, 4'd0, 16'h0, 1, 4'd1, 0, 16'h0, a, l);
    drive(0, 4'd0, 16'h0, 1, 4'd2, 0, 16'h0, a, l);
    drive(0, 4'd0, 16'h0, 1, 4'd4, 0, 16'h0, a, l);
    drive(0, 4'd0, 16'h0, 1, 4'd8, 0, 16'h0, a, l);
    drive(0, 4'd0, 16'h0, 1, 4'd9, 0, 16'h0, a, l);
    check("r9_refused_when_full", {15'b0, l}, 16'h0);
    for (int i = 1; i <= 4; i++)
      drive(0, 4'd0, 16'h0, 0, 4'd0, 1, 16'(i), a, l);
    idle();

    // Memory return and ALU r7 in the same cycle: memory first, r7 next.
    drive(0, 4'd0, 16'h0, 1, 4'd12, 0, 16'h0, a, l);
    drive(1, 4'd7, 16'h7777, 0, 4'd0, 1, 16'hC0DE, a, l);
    alu_until(4'd7, 16'h7777);
    idle();

    // WAW: load pending on r6, ALU BEEF to r6 waits for the return.
    drive(0, 4'd0, 16'h0, 1, 4'd6, 0, 16'h0, a, l);
    drive(1, 4'd6, 16'hBEEF, 0, 4'd0, 0, 16'h0, a, l);
    drive(1, 4'd6, 16'hBEEF, 0, 4'd0, 0, 16'h0, a, l);
    drive(1, 4'd6, 16'hBEEF, 0, 4'd0, 1, 16'h6666, a, l);
    alu_until(4'd6, 16'hBEEF);
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      mv = (pend.size() > 0) && ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 1), 4'($urandom), 16'($urandom),
            $urandom_range(0, 1), 4'($urandom), mv, 16'($urandom), a, l);
    end

    // Drain outstanding loads.
    for (int n = 0; n < 2 * LOAD_DEPTH && pend.size() > 0; n++)
      drive(0, 4'd0, 16'h0, 0, 4'd0, 1, 16'($urandom), a, l);
    check("drained", 16'(pend.size()), 16'h0);
    idle(); idle();
    check("scoreboard_empty", 16'(expq.size()), 16'h0);

    // Return with nothing outstanding: no write, sticky error.
    drive(0, 4'd0, 16'h0, 0, 4'd0, 1, 16'hDEAD, a, l);
    idle(); idle();

    // Two loads pending, then asynchronous reset between edges.
    drive(0, 4'd0, 16'h0, 1, 4'd10, 0, 16'h0, a, l);
    drive(0, 4'd0, 16'h0, 1, 4'd11, 0, 16'h0, a, l);
    idle();
    #1;
    I_NRESET = 1'b0;
    #1;
    pend.delete(); expq.delete(); err_m = 1'b0;
    check("async_rst_busy", O_BUSY, 16'h0);
    check("async_rst_err", {15'b0, O_ERR}, 16'h0);
    check("async_rst_enable", O_REG_ENABLE, 16'h0);
    @(negedge I_CLK); #1;
    I_NRESET = 1'b1;

    // FIFO must be empty after reset: a return now is an error, not a write.
    drive(0, 4'd0, 16'h0, 1, 4'd10, 0, 16'h0, a, l);
    drive(0, 4'd0, 16'h0, 0, 4'd0, 1, 16'h0A0A, a, l);
    drive(0, 4'd0, 16'h0, 0, 4'd0, 1, 16'hBAD0, a, l);
    idle(); idle();
    check("final_scoreboard_empty", 16'(expq.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
